// File: rtl/spi_slave.sv
// SPI target endpoint: oversampled sclk/cs_n/mosi, AXI-Stream rx/tx.
// Words move MSB first; CPOL/CPHA are taken from SPI_MODE.
module spi_slave #(
  parameter int DATA_WIDTH = 8,
  parameter int SPI_MODE   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  output logic                  busy,
  output logic                  rx_overrun_error,
  output logic                  tx_underrun_error,
  output logic                  frame_error
);

  localparam logic CPOL = 1'((SPI_MODE >> 1) & 1);
  localparam logic CPHA = 1'(SPI_MODE & 1);
  localparam int   CW   = $clog2(DATA_WIDTH + 1);
  localparam int   DW   = DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT
  } state_t;

  logic sclk_s1_q, sclk_s2_q, sclk_h_q;
  logic cs_s1_q, cs_s2_q, cs_h_q;
  logic mosi_s1_q, mosi_s2_q;
  logic warm_q, armed_q;

  state_t        state_q, state_d;
  logic [DW-1:0] tx_q, tx_d;
  logic [DW-1:0] rx_q, rx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] hold_q, hold_d;
  logic          hold_v_q, hold_v_d;
  logic [DW-1:0] m_data_q, m_data_d;
  logic          m_valid_q, m_valid_d;
  logic          first_q, first_d;
  logic          rld_q, rld_d;
  logic          upend_q, upend_d;
  logic          ov_q, ov_d;
  logic          ur_q, ur_d;
  logic          fe_q, fe_d;

  logic lead, trail, smp, shf;
  logic cs_fall, cs_rise;
  logic reload;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_s1_q <= CPOL;
      sclk_s2_q <= CPOL;
      sclk_h_q  <= CPOL;
      cs_s1_q   <= 1'b1;
      cs_s2_q   <= 1'b1;
      cs_h_q    <= 1'b1;
      mosi_s1_q <= 1'b0;
      mosi_s2_q <= 1'b0;
      warm_q    <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      sclk_s1_q <= sclk;
      sclk_s2_q <= sclk_s1_q;
      sclk_h_q  <= sclk_s2_q;
      cs_s1_q   <= cs_n;
      cs_s2_q   <= cs_s1_q;
      cs_h_q    <= cs_s2_q;
      mosi_s1_q <= mosi;
      mosi_s2_q <= mosi_s1_q;
      warm_q    <= 1'b1;
      // a frame already running at reset release must not be joined
      armed_q   <= armed_q | (warm_q & cs_s1_q & cs_s2_q);
    end
  end

  assign lead    = !cs_s2_q && (sclk_h_q == CPOL) && (sclk_s2_q != CPOL);
  assign trail   = !cs_s2_q && (sclk_h_q != CPOL) && (sclk_s2_q == CPOL);
  assign smp     = CPHA ? trail : lead;
  assign shf     = CPHA ? lead : trail;
  assign cs_fall = armed_q && cs_h_q && !cs_s2_q;
  assign cs_rise = !cs_h_q && cs_s2_q;

  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    hold_v_d  = hold_v_q;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    first_d   = first_q;
    rld_d     = rld_q;
    upend_d   = upend_q;
    ov_d      = 1'b0;
    ur_d      = 1'b0;
    fe_d      = 1'b0;
    reload    = 1'b0;

    if (m_valid_q && m_axis_tready) m_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          reload  = 1'b1;
          ur_d    = !hold_v_q;
          cnt_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        first_d = 1'b1;
        rld_d   = 1'b0;
        upend_d = 1'b0;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (shf) begin
          if (CPHA && first_q) begin
            first_d = 1'b0;
          end else if (!CPHA && rld_q) begin
            reload  = 1'b1;
            rld_d   = 1'b0;
            upend_d = !hold_v_q;
          end else begin
            tx_d = {tx_q[DW-2:0], 1'b0};
          end
        end
        if (smp) begin
          rx_d = {rx_q[DW-2:0], mosi_s2_q};
          // an empty reload is only an error once the next word begins
          if (upend_q) begin
            ur_d    = 1'b1;
            upend_d = 1'b0;
          end
          if (cnt_q == CW'(DW - 1)) begin
            cnt_d = '0;
            if (!m_valid_q || m_axis_tready) begin
              m_data_d  = {rx_q[DW-2:0], mosi_s2_q};
              m_valid_d = 1'b1;
            end else begin
              ov_d = 1'b1;
            end
            if (CPHA) begin
              reload  = 1'b1;
              first_d = 1'b1;
              upend_d = !hold_v_q;
            end else begin
              rld_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (reload) begin
      tx_d     = hold_v_q ? hold_q : '0;
      hold_v_d = 1'b0;
    end
    if (s_axis_tvalid && !hold_v_q) begin
      hold_d   = s_axis_tdata;
      hold_v_d = 1'b1;
    end

    if (cs_rise) begin
      fe_d    = (cnt_q != '0);
      cnt_d   = '0;
      rld_d   = 1'b0;
      upend_d = 1'b0;
      first_d = 1'b0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tx_q      <= '0;
      rx_q      <= '0;
      cnt_q     <= '0;
      hold_q    <= '0;
      hold_v_q  <= 1'b0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      first_q   <= 1'b0;
      rld_q     <= 1'b0;
      upend_q   <= 1'b0;
      ov_q      <= 1'b0;
      ur_q      <= 1'b0;
      fe_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      hold_v_q  <= hold_v_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      first_q   <= first_d;
      rld_q     <= rld_d;
      upend_q   <= upend_d;
      ov_q      <= ov_d;
      ur_q      <= ur_d;
      fe_q      <= fe_d;
    end
  end

  assign s_axis_tready     = !hold_v_q;
  assign m_axis_tdata      = m_data_q;
  assign m_axis_tvalid     = m_valid_q;
  assign miso              = (state_q == SHIFT) && tx_q[DW-1];
  assign miso_oe           = (state_q == SHIFT);
  assign busy              = (state_q != IDLE);
  assign rx_overrun_error  = ov_q;
  assign tx_underrun_error = ur_q;
  assign frame_error       = fe_q;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: one instance per SPI mode driven by a host model.
// A per-cycle compare process checks the rx stream against a word queue.
module tb_spi_slave;

  localparam int H = 6;

  logic       clk;
  logic       rst_n;
  logic [7:0] s_data;
  logic [3:0] s_vld;
  logic       m_rdy;
  logic [3:0] sclk;
  logic [3:0] cs_n;
  logic       mosi;

  wire  [3:0] s_rdy;
  wire  [3:0] m_vld;
  wire  [7:0] m_data [4];
  wire  [3:0] miso;
  wire  [3:0] miso_oe;
  wire  [3:0] busy;
  wire  [3:0] ov;
  wire  [3:0] ur;
  wire  [3:0] fe;

  int checks = 0;
  int fails  = 0;
  int act    = 0;
  logic [7:0] rxq [$];
  int ov_c [4];
  int ur_c [4];
  int fe_c [4];
  int e_ov [4];
  int e_ur [4];
  int e_fe [4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_slave #(.DATA_WIDTH(8), .SPI_MODE(g)) u_dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .s_axis_tdata      (s_data),
      .s_axis_tvalid     (s_vld[g]),
      .s_axis_tready     (s_rdy[g]),
      .m_axis_tdata      (m_data[g]),
      .m_axis_tvalid     (m_vld[g]),
      .m_axis_tready     (m_rdy),
      .sclk              (sclk[g]),
      .cs_n              (cs_n[g]),
      .mosi              (mosi),
      .miso              (miso[g]),
      .miso_oe           (miso_oe[g]),
      .busy              (busy[g]),
      .rx_overrun_error  (ov[g]),
      .tx_underrun_error (ur[g]),
      .frame_error       (fe[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string nm, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ov[i]) ov_c[i]++;
      if (ur[i]) ur_c[i]++;
      if (fe[i]) fe_c[i]++;
      if (i == act) begin
        if (m_vld[i]) begin
          if (rxq.size() == 0) begin
            chk("rx_spurious", m_vld[i], 0);
          end else begin
            chk("rx_data", m_data[i], rxq[0]);
            if (m_rdy) void'(rxq.pop_front());
          end
        end
      end else begin
        chk("idle_vld", m_vld[i], 0);
      end
    end
  end

  task automatic rst_chk(int m);
    chk("rst_tready", s_rdy[m], 1);
    chk("rst_tvalid", m_vld[m], 0);
    chk("rst_tdata", m_data[m], 0);
    chk("rst_miso", miso[m], 0);
    chk("rst_oe", miso_oe[m], 0);
    chk("rst_busy", busy[m], 0);
    chk("rst_err", {ov[m], ur[m], fe[m]}, 0);
  endtask

  task automatic cnt_chk(int m);
    chk("ov_count", ov_c[m], e_ov[m]);
    chk("ur_count", ur_c[m], e_ur[m]);
    chk("fe_count", fe_c[m], e_fe[m]);
  endtask

  task automatic feed(int m, logic [7:0] d);
    int n;
    @(negedge clk);
    s_data = d;
    s_vld[m] = 1'b1;
    n = 0;
    while (!s_rdy[m] && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk("feed_timeout", s_rdy[m], 1);
    @(negedge clk);
    s_vld[m] = 1'b0;
  endtask

  task automatic cs_lo(int m);
    @(negedge clk);
    act = m;
    cs_n[m] = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic cs_hi(int m);
    repeat (H) @(negedge clk);
    cs_n[m] = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic last(int m, logic [7:0] hw, bit lat);
    if (rxq.size() != 0 && !m_rdy) e_ov[m]++;
    else rxq.push_back(hw);
    if (lat) begin
      @(posedge clk);
      @(posedge clk);
      #1 chk("lat_early", m_vld[m], 0);
      @(posedge clk);
      #1 chk("lat_valid", m_vld[m], 1);
      chk("lat_data", m_data[m], hw);
    end
  endtask

  task automatic word(int m, logic [7:0] hw, int nb, bit lat,
                      output logic [7:0] got);
    logic cpol, cpha;
    cpol = m[1];
    cpha = m[0];
    got = '0;
    for (int i = 0; i < nb; i++) begin
      if (!cpha) begin
        mosi = hw[7-i];
        repeat (H) @(negedge clk);
        got = {got[6:0], miso[m]};
        sclk[m] = ~cpol;
        if (i == 7) last(m, hw, lat);
        repeat (H) @(negedge clk);
        sclk[m] = cpol;
      end else begin
        sclk[m] = ~cpol;
        mosi = hw[7-i];
        repeat (H) @(negedge clk);
        got = {got[6:0], miso[m]};
        sclk[m] = cpol;
        if (i == 7) last(m, hw, lat);
        repeat (H) @(negedge clk);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] got;
    for (int i = 0; i < 4; i++) begin
      ov_c[i] = 0; ur_c[i] = 0; fe_c[i] = 0;
      e_ov[i] = 0; e_ur[i] = 0; e_fe[i] = 0;
    end
    rst_n = 1'b0;
    s_data = '0;
    s_vld = '0;
    m_rdy = 1'b1;
    sclk = 4'b1100;
    cs_n = 4'hF;
    mosi = 1'b0;
    repeat (3) @(negedge clk);
    for (int m = 0; m < 4; m++) rst_chk(m);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // mode 0 basic exchange with latency pin
    feed(0, 8'hA5);
    cs_lo(0);
    chk("m0_busy", busy[0], 1);
    chk("m0_oe", miso_oe[0], 1);
    chk("m0_tready", s_rdy[0], 1);
    word(0, 8'h3C, 8, 1'b1, got);
    chk("m0_miso", got, 8'hA5);
    cs_hi(0);
    chk("m0_idle_busy", busy[0], 0);
    chk("m0_idle_oe", miso_oe[0], 0);
    chk("m0_rx", m_data[0], 8'h3C);
    cnt_chk(0);

    // modes 1..3
    for (int m = 1; m < 4; m++) begin
      feed(m, 8'h5A);
      cs_lo(m);
      word(m, 8'hC3, 8, 1'b0, got);
      chk("mode_miso", got, 8'h5A);
      cs_hi(m);
      chk("mode_rx", m_data[m], 8'hC3);
      cnt_chk(m);
    end

    // back-to-back, CPHA=0
    feed(0, 8'h01);
    cs_lo(0);
    feed(0, 8'h02);
    word(0, 8'h11, 8, 1'b0, got);
    chk("b2b_miso0", got, 8'h01);
    feed(0, 8'h03);
    word(0, 8'h22, 8, 1'b0, got);
    chk("b2b_miso1", got, 8'h02);
    word(0, 8'h33, 8, 1'b0, got);
    chk("b2b_miso2", got, 8'h03);
    cs_hi(0);
    chk("b2b_rx", m_data[0], 8'h33);
    cnt_chk(0);

    // back-to-back, CPHA=1
    feed(1, 8'hA1);
    cs_lo(1);
    feed(1, 8'hB2);
    word(1, 8'h0F, 8, 1'b0, got);
    chk("b2b1_miso0", got, 8'hA1);
    word(1, 8'hF0, 8, 1'b0, got);
    chk("b2b1_miso1", got, 8'hB2);
    cs_hi(1);
    cnt_chk(1);

    // underrun
    cs_lo(0);
    e_ur[0]++;
    word(0, 8'h96, 8, 1'b0, got);
    chk("ur_miso", got, 8'h00);
    cs_hi(0);
    chk("ur_pulse", ur_c[0], 1);
    cnt_chk(0);

    // overrun
    m_rdy = 1'b0;
    feed(0, 8'h12);
    cs_lo(0);
    feed(0, 8'h34);
    word(0, 8'hAA, 8, 1'b0, got);
    chk("ov_miso0", got, 8'h12);
    word(0, 8'h55, 8, 1'b0, got);
    chk("ov_miso1", got, 8'h34);
    cs_hi(0);
    chk("ov_held_vld", m_vld[0], 1);
    chk("ov_held_data", m_data[0], 8'hAA);
    chk("ov_pulse", ov_c[0], 1);
    cnt_chk(0);
    m_rdy = 1'b1;
    repeat (3) @(negedge clk);
    chk("ov_drain", m_vld[0], 0);

    // abort after 5 bits, then a clean frame
    feed(0, 8'h77);
    cs_lo(0);
    word(0, 8'hFF, 5, 1'b0, got);
    cs_hi(0);
    e_fe[0]++;
    chk("fe_pulse", fe_c[0], 1);
    cnt_chk(0);
    feed(0, 8'h7E);
    cs_lo(0);
    word(0, 8'h81, 8, 1'b0, got);
    chk("fe_next_miso", got, 8'h7E);
    cs_hi(0);
    chk("fe_next_rx", m_data[0], 8'h81);
    cnt_chk(0);

    // async reset mid-word
    feed(0, 8'hC3);
    cs_lo(0);
    feed(0, 8'h99);
    word(0, 8'hAA, 4, 1'b0, got);
    chk("pre_rst_tready", s_rdy[0], 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1 rst_chk(0);
    cs_n[0] = 1'b1;
    sclk[0] = 1'b0;
    mosi = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    feed(0, 8'h5C);
    cs_lo(0);
    word(0, 8'hF0, 8, 1'b0, got);
    chk("rst_next_miso", got, 8'h5C);
    cs_hi(0);
    chk("rst_next_rx", m_data[0], 8'hF0);
    cnt_chk(0);
    chk("rxq_empty", rxq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
